// File: rtl/mcp_rx_ack.sv
// Multi-channel MCP receiver: synchronises per-channel enable toggles, captures the
// quasi-static source data into valid/ready holding registers and returns an ack toggle.
module mcp_rx_ack #(
  parameter int DW       = 32,
  parameter int NCH      = 1,
  parameter int STAGES   = 2,
  parameter int ACK_MODE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    tgl_i,
  input  logic [NCH*DW-1:0] data_i,
  output logic [NCH*DW-1:0] data_o,
  output logic [NCH-1:0]    valid_o,
  input  logic [NCH-1:0]    ready_i,
  output logic [NCH-1:0]    ack_tgl_o,
  output logic [NCH-1:0]    ovf_o,
  input  logic              ovf_clr_i
);

  localparam int CW = $clog2(STAGES + 2);

  logic [NCH-1:0] sync_q [STAGES];
  logic [NCH-1:0] hist_q;
  logic [CW-1:0]  warm_q;
  logic           warm_busy;
  logic [NCH-1:0] pulse;

  assign warm_busy = (warm_q != '0);
  // Edge detection is muted until the chains have flushed whatever they held at release.
  assign pulse     = warm_busy ? '0 : (sync_q[STAGES-1] ^ hist_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      hist_q <= '0;
      warm_q <= CW'(STAGES + 1);
    end else begin
      sync_q[0] <= tgl_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[STAGES-1];
      if (warm_busy) warm_q <= warm_q - CW'(1);
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic          accept;
    logic          load;
    logic          drop;
    logic          ack_ev;
    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          ack_q;
    logic          ovf_q;

    assign accept = valid_q & ready_i[c];
    // A pulse loads when the register is empty or being drained in the same edge.
    assign load   = pulse[c] & (~valid_q | ready_i[c]);
    assign drop   = pulse[c] & valid_q & ~ready_i[c];
    assign ack_ev = (ACK_MODE != 0) ? accept : pulse[c];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q  <= '0;
        valid_q <= 1'b0;
        ack_q   <= 1'b0;
        ovf_q   <= 1'b0;
      end else begin
        if (load) data_q <= data_i[c*DW +: DW];
        if (load) valid_q <= 1'b1;
        else if (accept) valid_q <= 1'b0;
        if (ack_ev) ack_q <= ~ack_q;
        if (drop) ovf_q <= 1'b1;
        else if (ovf_clr_i) ovf_q <= 1'b0;
      end
    end

    assign data_o[c*DW +: DW] = data_q;
    assign valid_o[c]         = valid_q;
    assign ack_tgl_o[c]       = ack_q;
    assign ovf_o[c]           = ovf_q;
  end

endmodule

// File: tb/tb_mcp_rx_ack.sv
// Bench for mcp_rx_ack: two instances (ACK_MODE 1 and 0) share stimulus; directed table,
// hand sequences for reset corners, then random traffic against a reference model.
module tb_mcp_rx_ack;

  localparam int DW = 8;
  localparam int NCH = 2;
  localparam int STAGES = 2;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    tgl_i;
  logic [NCH*DW-1:0] data_i;
  logic [NCH-1:0]    ready_i;
  logic              ovf_clr_i;
  logic [NCH*DW-1:0] data1, data0;
  logic [NCH-1:0]    val1, val0, ack1, ack0, ovf1, ovf0;

  mcp_rx_ack #(.DW(DW), .NCH(NCH), .STAGES(STAGES), .ACK_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tgl_i(tgl_i), .data_i(data_i), .data_o(data1),
    .valid_o(val1), .ready_i(ready_i), .ack_tgl_o(ack1), .ovf_o(ovf1), .ovf_clr_i(ovf_clr_i)
  );

  mcp_rx_ack #(.DW(DW), .NCH(NCH), .STAGES(STAGES), .ACK_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tgl_i(tgl_i), .data_i(data_i), .data_o(data0),
    .valid_o(val0), .ready_i(ready_i), .ack_tgl_o(ack0), .ovf_o(ovf0), .ovf_clr_i(ovf_clr_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference model state
  logic [NCH-1:0]    smp_q[$];
  int                ecnt;
  logic [NCH-1:0]    m_val, m_a1, m_a0, m_ovf;
  logic [NCH*DW-1:0] m_dat;

  task automatic do_reset(input logic [NCH-1:0] t);
    rst_n = 1'b0;
    tgl_i = t;
    data_i = '0;
    ready_i = '0;
    ovf_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    smp_q.delete();
    ecnt = 0;
    m_val = '0; m_a1 = '0; m_a0 = '0; m_ovf = '0; m_dat = '0;
  endtask

  // A toggle sampled at edge n acts at edge n+STAGES, once the warm-up window has passed.
  task automatic model_edge();
    logic [NCH-1:0] a, b;
    logic fire, acc, set;
    smp_q.push_back(tgl_i);
    ecnt++;
    for (int c = 0; c < NCH; c++) begin
      fire = 1'b0;
      if (ecnt >= STAGES + 2) begin
        a = smp_q[ecnt-STAGES-1];
        b = smp_q[ecnt-STAGES-2];
        fire = a[c] ^ b[c];
      end
      acc = m_val[c] & ready_i[c];
      set = 1'b0;
      if (acc) m_a1[c] = ~m_a1[c];
      if (fire) m_a0[c] = ~m_a0[c];
      if (fire) begin
        if (!m_val[c] || ready_i[c]) begin
          m_dat[c*DW +: DW] = data_i[c*DW +: DW];
          m_val[c] = 1'b1;
        end else begin
          set = 1'b1;
        end
      end else if (acc) begin
        m_val[c] = 1'b0;
      end
      m_ovf[c] = set ? 1'b1 : (ovf_clr_i ? 1'b0 : m_ovf[c]);
    end
  endtask

  typedef struct packed {
    logic [1:0]  tgl;
    logic [15:0] dat;
    logic [1:0]  rdy;
    logic        clr;
    logic [1:0]  e_val;
    logic [15:0] e_dat;
    logic [1:0]  e_a1;
    logic [1:0]  e_a0;
    logic [1:0]  e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] t, input logic [15:0] d, input logic [1:0] r,
                              input logic cl, input logic [1:0] ev, input logic [15:0] ed,
                              input logic [1:0] ea1, input logic [1:0] ea0, input logic [1:0] eo);
    vec_t v;
    v.tgl = t; v.dat = d; v.rdy = r; v.clr = cl;
    v.e_val = ev; v.e_dat = ed; v.e_a1 = ea1; v.e_a0 = ea0; v.e_ovf = eo;
    return v;
  endfunction

  initial begin
    // rows are edges 1.. after release; toggles act STAGES edges after sampling
    vecs.push_back(mk(2'b00, 16'h0000, 2'b00, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b00, 16'h0000, 2'b00, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b00, 16'h0000, 2'b00, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01, 16'h00A5, 2'b00, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01, 16'h00A5, 2'b00, 0, 2'b00, 16'h0000, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01, 16'h00A5, 2'b00, 0, 2'b01, 16'h00A5, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(2'b01, 16'h00A5, 2'b00, 0, 2'b01, 16'h00A5, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(2'b01, 16'h00A5, 2'b01, 0, 2'b00, 16'h00A5, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 16'h0033, 2'b00, 0, 2'b00, 16'h00A5, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 16'h0033, 2'b00, 0, 2'b00, 16'h00A5, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 16'h0033, 2'b00, 0, 2'b01, 16'h0033, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01, 16'h0044, 2'b00, 0, 2'b01, 16'h0033, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01, 16'h0044, 2'b00, 0, 2'b01, 16'h0033, 2'b01, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01, 16'h0044, 2'b00, 0, 2'b01, 16'h0033, 2'b01, 2'b01, 2'b01));
    vecs.push_back(mk(2'b01, 16'h0044, 2'b00, 1, 2'b01, 16'h0033, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(2'b01, 16'h0044, 2'b01, 0, 2'b00, 16'h0033, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 16'h0055, 2'b00, 0, 2'b00, 16'h0033, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 16'h0055, 2'b00, 0, 2'b00, 16'h0033, 2'b00, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 16'h0055, 2'b00, 0, 2'b01, 16'h0055, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01, 16'h0066, 2'b00, 0, 2'b01, 16'h0055, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01, 16'h0066, 2'b00, 0, 2'b01, 16'h0055, 2'b00, 2'b00, 2'b00));
    vecs.push_back(mk(2'b01, 16'h0066, 2'b01, 0, 2'b01, 16'h0066, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(2'b01, 16'h0066, 2'b00, 0, 2'b01, 16'h0066, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 16'h1166, 2'b10, 0, 2'b01, 16'h0066, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 16'h1166, 2'b10, 0, 2'b01, 16'h0066, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(2'b11, 16'h1166, 2'b10, 0, 2'b11, 16'h1166, 2'b01, 2'b11, 2'b00));
    vecs.push_back(mk(2'b11, 16'h1166, 2'b10, 0, 2'b01, 16'h1166, 2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b01, 16'h2266, 2'b10, 0, 2'b01, 16'h1166, 2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b01, 16'h2266, 2'b10, 0, 2'b01, 16'h1166, 2'b11, 2'b11, 2'b00));
    vecs.push_back(mk(2'b01, 16'h2266, 2'b10, 0, 2'b11, 16'h2266, 2'b11, 2'b01, 2'b00));
    vecs.push_back(mk(2'b01, 16'h2266, 2'b10, 0, 2'b01, 16'h2266, 2'b01, 2'b01, 2'b00));
    // overflow set coincides with clear: set wins
    vecs.push_back(mk(2'b00, 16'h2233, 2'b00, 0, 2'b01, 16'h2266, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 16'h2233, 2'b00, 0, 2'b01, 16'h2266, 2'b01, 2'b01, 2'b00));
    vecs.push_back(mk(2'b00, 16'h2233, 2'b00, 1, 2'b01, 16'h2266, 2'b01, 2'b00, 2'b01));
    vecs.push_back(mk(2'b00, 16'h2233, 2'b00, 1, 2'b01, 16'h2266, 2'b01, 2'b00, 2'b00));

    // reset release with tgl_i[0] already high: no capture
    do_reset(2'b01);
    check("rst val", {30'd0, val1}, 32'd0);
    check("rst ack", {28'd0, ack1, ack0}, 32'd0);
    check("rst dat", {16'd0, data1}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("warm%0d val", i), {28'd0, val1, val0}, 32'd0);
      check($sformatf("warm%0d ack", i), {28'd0, ack1, ack0}, 32'd0);
      check($sformatf("warm%0d ovf", i), {28'd0, ovf1, ovf0}, 32'd0);
    end

    // directed table
    do_reset(2'b00);
    for (int i = 0; i < vecs.size(); i++) begin
      tgl_i = vecs[i].tgl;
      data_i = vecs[i].dat;
      ready_i = vecs[i].rdy;
      ovf_clr_i = vecs[i].clr;
      @(posedge clk); #1;
      check($sformatf("row%0d val1", i + 1), {30'd0, val1}, {30'd0, vecs[i].e_val});
      check($sformatf("row%0d val0", i + 1), {30'd0, val0}, {30'd0, vecs[i].e_val});
      check($sformatf("row%0d dat1", i + 1), {16'd0, data1}, {16'd0, vecs[i].e_dat});
      check($sformatf("row%0d dat0", i + 1), {16'd0, data0}, {16'd0, vecs[i].e_dat});
      check($sformatf("row%0d ack1", i + 1), {30'd0, ack1}, {30'd0, vecs[i].e_a1});
      check($sformatf("row%0d ack0", i + 1), {30'd0, ack0}, {30'd0, vecs[i].e_a0});
      check($sformatf("row%0d ovf1", i + 1), {30'd0, ovf1}, {30'd0, vecs[i].e_ovf});
      check($sformatf("row%0d ovf0", i + 1), {30'd0, ovf0}, {30'd0, vecs[i].e_ovf});
    end

    // mid-transfer reset: toggle sampled, reset before capture
    ovf_clr_i = 1'b0;
    tgl_i = 2'b01;
    data_i = 16'h0077;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst val", {28'd0, val1, val0}, 32'd0);
    check("midrst dat", {data1, data0}, 32'd0);
    check("midrst ack", {28'd0, ack1, ack0}, 32'd0);
    check("midrst ovf", {28'd0, ovf1, ovf0}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("postrst%0d val", i), {28'd0, val1, val0}, 32'd0);
    end

    // random traffic against the model
    do_reset(2'($urandom_range(0, 3)));
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 5) == 0) begin
          tgl_i[c] = ~tgl_i[c];
          data_i[c*DW +: DW] = 8'($urandom);
        end
      end
      ready_i = 2'($urandom_range(0, 3));
      ovf_clr_i = ($urandom_range(0, 15) == 0);
      model_edge();
      @(posedge clk); #1;
      check("rnd val1", {30'd0, val1}, {30'd0, m_val});
      check("rnd val0", {30'd0, val0}, {30'd0, m_val});
      check("rnd dat1", {16'd0, data1}, {16'd0, m_dat});
      check("rnd dat0", {16'd0, data0}, {16'd0, m_dat});
      check("rnd ack1", {30'd0, ack1}, {30'd0, m_a1});
      check("rnd ack0", {30'd0, ack0}, {30'd0, m_a0});
      check("rnd ovf1", {30'd0, ovf1}, {30'd0, m_ovf});
      check("rnd ovf0", {30'd0, ovf0}, {30'd0, m_ovf});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
